// File: rtl/scan_chain_ctrl.sv
// Parametrised scan register with CAPTURE / SHIFT / UPDATE command controller.
// Optional UPDATE parity guard enabled by defining SCAN_CHAIN_PARITY_EN.
module scan_chain_ctrl #(
    parameter int                 WIDTH     = 16,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    localparam int                CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] len,
    output logic             ready,
    output logic             busy,
    output logic             done,
    input  logic             scan_in,
    output logic             scan_out,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
`ifdef SCAN_CHAIN_PARITY_EN
   ,input  logic             par_in,
    output logic             par_err
`endif
);

    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_CAPTURE = 2'b01;
    localparam logic [1:0] OP_SHIFT   = 2'b10;
    localparam logic [1:0] OP_UPDATE  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_SHIFT,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  shift_reg;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  len_clamped;
    logic              accept;
`ifdef SCAN_CHAIN_PARITY_EN
    logic              par_q;
`endif

    assign accept   = (state == S_IDLE) && start;
    assign scan_out = shift_reg[0];

    // A length of zero or anything past WIDTH means a full-width shift.
    always_comb begin
        len_clamped = len;
        if (len == '0 || len > CNT_W'(WIDTH))
            len_clamped = CNT_W'(WIDTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_NOP:     state_nxt = S_DONE;
                        OP_CAPTURE: state_nxt = S_CAPTURE;
                        OP_SHIFT:   state_nxt = S_SHIFT;
                        OP_UPDATE:  state_nxt = S_UPDATE;
                        default:    state_nxt = S_DONE;
                    endcase
                end
            end
            S_CAPTURE: state_nxt = S_DONE;
            S_UPDATE:  state_nxt = S_DONE;
            S_SHIFT:   if (cnt == CNT_W'(1)) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ready = (state == S_IDLE);
        busy  = (state != S_IDLE);
        done  = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            data_out  <= RESET_VAL;
            cnt       <= '0;
`ifdef SCAN_CHAIN_PARITY_EN
            par_q     <= 1'b0;
            par_err   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && op == OP_SHIFT)
                        cnt <= len_clamped;
`ifdef SCAN_CHAIN_PARITY_EN
                    if (accept && op == OP_UPDATE)
                        par_q <= par_in;
                    if (accept && op == OP_CAPTURE)
                        par_err <= 1'b0;
`endif
                end
                S_CAPTURE: shift_reg <= data_in;
                S_SHIFT: begin
                    shift_reg <= {scan_in, shift_reg[WIDTH-1:1]};
                    cnt       <= cnt - CNT_W'(1);
                end
                S_UPDATE: begin
`ifdef SCAN_CHAIN_PARITY_EN
                    // Parity mismatch protects the live register and latches a sticky error.
                    if ((^shift_reg) != par_q)
                        par_err <= 1'b1;
                    else
                        data_out <= shift_reg;
`else
                    data_out <= shift_reg;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
